alu_issue_stage: RTL and testbench

Issue and writeback stage placed directly around the 32-bit combinational ALU. It accepts register-to-register and register-to-immediate commands over a valid/ready handshake, reads operands from an 8×32 register file, and drives the ALU's operand and opcode inputs from registers. One cycle later it captures the ALU result and overflow flag, writes the result back, and reports it. It sustains one command per cycle using a result-forwarding path, and can halt on signed overflow until software clears the condition.

---
 rtl/alu_issue_stage_if.sv | 37 +++
 rtl/alu_issue_stage.sv | 121 ++++++++++++
 tb/tb_alu_issue_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-side and result signals of the ALU issue/writeback stage.
// slave is the stage's own view; master is the view of whatever surrounds it.
interface alu_issue_stage_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs1;
  logic [2:0]  cmd_rs2;
  logic        cmd_use_imm;
  logic [31:0] cmd_imm;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [2:0]  alu_aluop;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        ovf_clr;
  logic        res_valid;
  logic [2:0]  res_rd;
  logic [31:0] res_data;
  logic        res_overflow;
  logic        ovf_sticky;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    input  alu_result, alu_overflow, ovf_clr,
    output cmd_ready, alu_operand1, alu_operand2, alu_aluop,
    output res_valid, res_rd, res_data, res_overflow, ovf_sticky
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    output alu_result, alu_overflow, ovf_clr,
    input  cmd_ready, alu_operand1, alu_operand2, alu_aluop,
    input  res_valid, res_rd, res_data, res_overflow, ovf_sticky
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around an external combinational ALU: accept edge N, result at edge N+1.
// cmd_ready depends only on state; it drops while halted on overflow until ovf_clr.
module alu_issue_stage #(
  parameter bit HALT_ON_OVF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave io
);
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] rf_q [8];
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [2:0]  ex_rd_q, ex_rd_d;
  logic        ex_vld_q, ex_vld_d;
  logic        res_vld_q, res_vld_d;
  logic [2:0]  res_rd_q, res_rd_d;
  logic [31:0] res_dat_q, res_dat_d;
  logic        res_ovf_q, res_ovf_d;
  logic        sticky_q, sticky_d;
  logic        accept, ovf_wb, fwd1, fwd2;

  always_comb begin
    accept    = io.cmd_valid && (state_q == ST_RUN);
    ovf_wb    = ex_vld_q && io.alu_overflow;
    // The instruction in EX writes back on the same edge we read, so bypass its result.
    fwd1      = ex_vld_q && (io.cmd_rs1 == ex_rd_q);
    fwd2      = ex_vld_q && (io.cmd_rs2 == ex_rd_q);

    op1_d     = op1_q;
    op2_d     = op2_q;
    aluop_d   = aluop_q;
    ex_rd_d   = ex_rd_q;
    ex_vld_d  = accept;
    if (accept) begin
      op1_d   = fwd1 ? io.alu_result : rf_q[io.cmd_rs1];
      if (io.cmd_use_imm) begin
        op2_d = io.cmd_imm;
      end else begin
        op2_d = fwd2 ? io.alu_result : rf_q[io.cmd_rs2];
      end
      aluop_d = io.cmd_op;
      ex_rd_d = io.cmd_rd;
    end

    res_vld_d = ex_vld_q;
    res_rd_d  = res_rd_q;
    res_dat_d = res_dat_q;
    res_ovf_d = res_ovf_q;
    if (ex_vld_q) begin
      res_rd_d  = ex_rd_q;
      res_dat_d = io.alu_result;
      res_ovf_d = io.alu_overflow;
    end

    // A set on the same edge as a clear takes priority.
    sticky_d = sticky_q;
    if (ovf_wb) begin
      sticky_d = 1'b1;
    end else if (io.ovf_clr) begin
      sticky_d = 1'b0;
    end

    state_d = state_q;
    if (ovf_wb && HALT_ON_OVF) begin
      state_d = ST_HALT;
    end else if (io.ovf_clr) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      op1_q     <= '0;
      op2_q     <= '0;
      aluop_q   <= '0;
      ex_rd_q   <= '0;
      ex_vld_q  <= 1'b0;
      res_vld_q <= 1'b0;
      res_rd_q  <= '0;
      res_dat_q <= '0;
      res_ovf_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      aluop_q   <= aluop_d;
      ex_rd_q   <= ex_rd_d;
      ex_vld_q  <= ex_vld_d;
      res_vld_q <= res_vld_d;
      res_rd_q  <= res_rd_d;
      res_dat_q <= res_dat_d;
      res_ovf_q <= res_ovf_d;
      sticky_q  <= sticky_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else if (ex_vld_q) begin
      rf_q[ex_rd_q] <= io.alu_result;
    end
  end

  assign io.cmd_ready    = (state_q == ST_RUN);
  assign io.alu_operand1 = op1_q;
  assign io.alu_operand2 = op2_q;
  assign io.alu_aluop    = aluop_q;
  assign io.res_valid    = res_vld_q;
  assign io.res_rd       = res_rd_q;
  assign io.res_data     = res_dat_q;
  assign io.res_overflow = res_ovf_q;
  assign io.ovf_sticky   = sticky_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed vectors plus hand sequences for the ALU issue stage; two DUTs share stimulus,
// one halting on overflow and one not.
module tb_alu_issue_stage;
  localparam logic [2:0] OP_CPL = 3'd0, OP_AND = 3'd1, OP_XOR = 3'd2, OP_OR  = 3'd3,
                         OP_DEC = 3'd4, OP_ADD = 3'd5, OP_SUB = 3'd6, OP_INC = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
  logic        cmd_use_imm;
  logic [31:0] cmd_imm;
  logic        ovf_clr;
  int          n_chk;
  int          n_err;
  vec_t        tbl [13];

  alu_issue_stage_if ifh ();
  alu_issue_stage_if ifn ();

  alu_issue_stage #(.HALT_ON_OVF(1'b1)) u_dut_h (.clk(clk), .rst_n(rst_n), .io(ifh.slave));
  alu_issue_stage #(.HALT_ON_OVF(1'b0)) u_dut_n (.clk(clk), .rst_n(rst_n), .io(ifn.slave));

  // ALU model: complement is two's-complement negation; overflow only for add/sub.
  function automatic logic [32:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      OP_CPL: r = 32'd0 - a;
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      OP_OR:  r = a | b;
      OP_DEC: r = a - 32'd1;
      OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = a + 32'd1;
    endcase
    return {v, r};
  endfunction

  always_comb {ifh.alu_overflow, ifh.alu_result} = alu_model(ifh.alu_aluop, ifh.alu_operand1, ifh.alu_operand2);
  always_comb {ifn.alu_overflow, ifn.alu_result} = alu_model(ifn.alu_aluop, ifn.alu_operand1, ifn.alu_operand2);

  assign ifh.cmd_valid = cmd_valid;    assign ifn.cmd_valid = cmd_valid;
  assign ifh.cmd_op = cmd_op;          assign ifn.cmd_op = cmd_op;
  assign ifh.cmd_rd = cmd_rd;          assign ifn.cmd_rd = cmd_rd;
  assign ifh.cmd_rs1 = cmd_rs1;        assign ifn.cmd_rs1 = cmd_rs1;
  assign ifh.cmd_rs2 = cmd_rs2;        assign ifn.cmd_rs2 = cmd_rs2;
  assign ifh.cmd_use_imm = cmd_use_imm; assign ifn.cmd_use_imm = cmd_use_imm;
  assign ifh.cmd_imm = cmd_imm;        assign ifn.cmd_imm = cmd_imm;
  assign ifh.ovf_clr = ovf_clr;        assign ifn.ovf_clr = ovf_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [31:0] imm);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_use_imm = use_imm; cmd_imm = imm; cmd_valid = 1'b1;
  endtask

  // Single isolated command on the halting DUT; called at a negedge.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic use_imm,
                         input logic [31:0] imm, input logic [31:0] exp_data, input logic exp_ovf);
    issue(op, rd, rs1, rs2, use_imm, imm);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, " res_valid"}, {31'd0, ifh.res_valid}, 32'd1);
    chk({tag, " res_rd"}, {29'd0, ifh.res_rd}, {29'd0, rd});
    chk({tag, " res_data"}, ifh.res_data, exp_data);
    chk({tag, " res_overflow"}, {31'd0, ifh.res_overflow}, {31'd0, exp_ovf});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; ovf_clr = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0;

    tbl[0]  = '{OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h5,        32'h5,        1'b0};
    tbl[1]  = '{OP_CPL, 3'd2, 3'd1, 3'd0, 1'b1, 32'h0,        32'hFFFFFFFB, 1'b0};
    tbl[2]  = '{OP_AND, 3'd3, 3'd2, 3'd0, 1'b1, 32'hFF,       32'hFB,       1'b0};
    tbl[3]  = '{OP_XOR, 3'd4, 3'd3, 3'd1, 1'b0, 32'h0,        32'hFE,       1'b0};
    tbl[4]  = '{OP_OR,  3'd5, 3'd4, 3'd0, 1'b1, 32'h100,      32'h1FE,      1'b0};
    tbl[5]  = '{OP_ADD, 3'd6, 3'd5, 3'd4, 1'b0, 32'h0,        32'h2FC,      1'b0};
    tbl[6]  = '{OP_SUB, 3'd7, 3'd1, 3'd6, 1'b0, 32'h0,        32'hFFFFFD09, 1'b0};
    tbl[7]  = '{OP_INC, 3'd0, 3'd7, 3'd0, 1'b1, 32'h0,        32'hFFFFFD0A, 1'b0};
    tbl[8]  = '{OP_DEC, 3'd2, 3'd2, 3'd0, 1'b1, 32'h0,        32'hFFFFFFFA, 1'b0};
    tbl[9]  = '{OP_ADD, 3'd3, 3'd3, 3'd0, 1'b1, 32'hFFFFFFFF, 32'hFA,       1'b0};
    tbl[10] = '{OP_OR,  3'd4, 3'd1, 3'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    tbl[11] = '{OP_INC, 3'd5, 3'd4, 3'd0, 1'b1, 32'h0,        32'h0,        1'b0};
    tbl[12] = '{OP_DEC, 3'd6, 3'd5, 3'd0, 1'b1, 32'h0,        32'hFFFFFFFF, 1'b0};

    do_reset();
    chk("reset cmd_ready", {31'd0, ifh.cmd_ready}, 32'd1);
    chk("reset res_valid", {31'd0, ifh.res_valid}, 32'd0);
    chk("reset ovf_sticky", {31'd0, ifh.ovf_sticky}, 32'd0);
    chk("reset alu_operand1", ifh.alu_operand1, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
              tbl[i].use_imm, tbl[i].imm, tbl[i].exp_data, tbl[i].exp_ovf);
    end

    // Asynchronous reset while a command sits in EX.
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h1234);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst alu_operand1", ifh.alu_operand1, 32'd0);
    chk("midrst alu_operand2", ifh.alu_operand2, 32'd0);
    chk("midrst alu_aluop", {29'd0, ifh.alu_aluop}, 32'd0);
    chk("midrst res_valid", {31'd0, ifh.res_valid}, 32'd0);
    chk("midrst res_rd", {29'd0, ifh.res_rd}, 32'd0);
    chk("midrst res_data", ifh.res_data, 32'd0);
    chk("midrst res_overflow", {31'd0, ifh.res_overflow}, 32'd0);
    chk("midrst ovf_sticky", {31'd0, ifh.ovf_sticky}, 32'd0);
    chk("midrst cmd_ready", {31'd0, ifh.cmd_ready}, 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst res_valid a", {31'd0, ifh.res_valid}, 32'd0);
    @(negedge clk);
    chk("postrst res_valid b", {31'd0, ifh.res_valid}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      run_cmd($sformatf("rf%0d zero", r), OP_OR, r[2:0], r[2:0], 3'd0, 1'b1, 32'h0, 32'h0, 1'b0);
    end

    // Dependent back-to-back commands through the forwarding path.
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
    @(negedge clk);
    issue(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b first valid", {31'd0, ifh.res_valid}, 32'd1);
    chk("b2b first rd", {29'd0, ifh.res_rd}, 32'd1);
    chk("b2b first data", ifh.res_data, 32'd5);
    @(negedge clk);
    chk("b2b second valid", {31'd0, ifh.res_valid}, 32'd1);
    chk("b2b second rd", {29'd0, ifh.res_rd}, 32'd2);
    chk("b2b second data", ifh.res_data, 32'd10);
    chk("b2b second ovf", {31'd0, ifh.res_overflow}, 32'd0);

    // Add overflow halts the stage; held command is blocked until ovf_clr.
    run_cmd("set max", OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("addovf data", ifh.res_data, 32'h80000000);
    chk("addovf res_overflow", {31'd0, ifh.res_overflow}, 32'd1);
    chk("addovf sticky", {31'd0, ifh.ovf_sticky}, 32'd1);
    chk("addovf cmd_ready", {31'd0, ifh.cmd_ready}, 32'd0);
    issue(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("halt blocked res_valid %0d", k), {31'd0, ifh.res_valid}, 32'd0);
      chk($sformatf("halt cmd_ready %0d", k), {31'd0, ifh.cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr cmd_ready", {31'd0, ifh.cmd_ready}, 32'd1);
    chk("clr sticky", {31'd0, ifh.ovf_sticky}, 32'd0);
    run_cmd("r4 untouched", OP_OR, 3'd5, 3'd4, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0);

    // Sub overflow with ovf_clr on the same writeback edge: set wins.
    run_cmd("set min", OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 32'h80000000, 32'h80000000, 1'b0);
    issue(OP_SUB, 3'd2, 3'd1, 3'd0, 1'b1, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("subovf data", ifh.res_data, 32'h7FFFFFFF);
    chk("subovf res_overflow", {31'd0, ifh.res_overflow}, 32'd1);
    chk("subovf sticky", {31'd0, ifh.ovf_sticky}, 32'd1);
    chk("subovf cmd_ready", {31'd0, ifh.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("subovf held halt", {31'd0, ifh.cmd_ready}, 32'd0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("subclr cmd_ready", {31'd0, ifh.cmd_ready}, 32'd1);
    chk("subclr sticky", {31'd0, ifh.ovf_sticky}, 32'd0);

    // Non-halting instance: overflow only sets the sticky flag.
    do_reset();
    issue(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF);
    @(negedge clk);
    issue(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("noh data", ifn.res_data, 32'h80000000);
    chk("noh res_overflow", {31'd0, ifn.res_overflow}, 32'd1);
    chk("noh sticky", {31'd0, ifn.ovf_sticky}, 32'd1);
    chk("noh cmd_ready", {31'd0, ifn.cmd_ready}, 32'd1);
    issue(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'd7);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("noh next valid", {31'd0, ifn.res_valid}, 32'd1);
    chk("noh next rd", {29'd0, ifn.res_rd}, 32'd4);
    chk("noh next data", ifn.res_data, 32'd7);
    chk("noh sticky held", {31'd0, ifn.ovf_sticky}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
